// File: rtl/lvdc_timing_pkg.sv
// rtl/lvdc_timing_pkg.sv - shared types and constants for the LVDC timing sequencer
package lvdc_timing_pkg;

  // Bit times per phase unless the top is overridden
  localparam int WORD_BITS_DEFAULT = 26;

  // Sub-phases per bit time; the 3-bit SP counter only supports 8
  localparam int SP_COUNT_FIXED = 8;

  // Sub-phase positions of the six timing pulses
  localparam logic [2:0] SP_V1 = 3'd0;
  localparam logic [2:0] SP_W1 = 3'd1;
  localparam logic [2:0] SP_X3 = 3'd3;
  localparam logic [2:0] SP_Z3 = 3'd5;
  localparam logic [2:0] SP_ZN = 3'd6;
  localparam logic [2:0] SP_Y7 = 3'd7;

  // Instruction-cycle phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PA   = 2'd1,
    ST_PB   = 2'd2,
    ST_PC   = 2'd3
  } lvdc_state_e;

endpackage

// File: rtl/lvdc_subphase_decode.sv
// rtl/lvdc_subphase_decode.sv - sub-phase counter with registered pulse decode
module lvdc_subphase_decode
  import lvdc_timing_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_freeze,
  output logic [2:0] o_sp,
  output logic       o_v1,
  output logic       o_w1,
  output logic       o_x3,
  output logic       o_z3,
  output logic       o_zn,
  output logic       o_y7
);

  logic [2:0] r_sp;
  logic [5:0] r_pulse;
  logic [2:0] w_sp_nxt;

  assign w_sp_nxt = r_sp + 3'd1;

  // SP advances and wraps; pulses are decoded from the upcoming SP so each
  // flop is high exactly while SP holds its position. Freeze holds SP and
  // forces every pulse low. Reset parks SP at 7 so the first edge lands on 0.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sp    <= SP_Y7;
      r_pulse <= 6'b0;
    end else if (i_freeze) begin
      r_pulse <= 6'b0;
    end else begin
      r_sp    <= w_sp_nxt;
      r_pulse <= {w_sp_nxt == SP_V1,
                  w_sp_nxt == SP_W1,
                  w_sp_nxt == SP_X3,
                  w_sp_nxt == SP_Z3,
                  w_sp_nxt == SP_ZN,
                  w_sp_nxt == SP_Y7};
    end
  end

  assign o_sp = r_sp;
  assign o_v1 = r_pulse[5];
  assign o_w1 = r_pulse[4];
  assign o_x3 = r_pulse[3];
  assign o_z3 = r_pulse[2];
  assign o_zn = r_pulse[1];
  assign o_y7 = r_pulse[0];

endmodule

// File: rtl/lvdc_timing_seq.sv
// rtl/lvdc_timing_seq.sv - LVDC instruction-cycle timing sequencer (PA/PB/PC phases)
module lvdc_timing_seq
  import lvdc_timing_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEFAULT,
  parameter int SP_COUNT  = SP_COUNT_FIXED
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_start,
  input  logic [3:0] i_opin,
  input  logic       i_short,
  input  logic       i_halt,
  output logic       o_v1,
  output logic       o_w1,
  output logic       o_x3,
  output logic       o_z3,
  output logic       o_zn,
  output logic       o_y7,
  output logic       o_pav,
  output logic       o_pavn,
  output logic       o_pbv,
  output logic       o_pcv,
  output logic       o_op1v,
  output logic       o_op2v,
  output logic       o_op3v,
  output logic       o_op4v,
  output logic       o_op1vn,
  output logic       o_op2vn,
  output logic       o_op3vn,
  output logic       o_op4vn,
  output logic [4:0] o_bit,
  output logic       o_busy
);

  localparam logic [2:0] SP_WRAP  = 3'(SP_COUNT - 1);
  localparam logic [4:0] BIT_LAST = 5'(WORD_BITS - 1);

  lvdc_state_e r_state;
  lvdc_state_e w_state_nxt;
  logic [4:0]  r_bit;
  logic [4:0]  w_bit_nxt;
  logic [3:0]  r_op;
  logic        r_short;
  logic        r_busy;
  logic        r_pav;
  logic        r_pbv;
  logic        r_pcv;
  logic [2:0]  w_sp;
  logic        w_wrap;
  logic        w_last_bit;
  logic        w_sample;
  logic        w_load;

  lvdc_subphase_decode u_subphase (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_freeze (i_halt),
    .o_sp     (w_sp),
    .o_v1     (o_v1),
    .o_w1     (o_w1),
    .o_x3     (o_x3),
    .o_z3     (o_z3),
    .o_zn     (o_zn),
    .o_y7     (o_y7)
  );

  // Everything in the sequencer happens on the SP 7->0 wrap; HALT suppresses
  // the wrap, so a coincident START is simply seen again after resume.
  assign w_wrap     = (w_sp == SP_WRAP) && !i_halt;
  assign w_last_bit = (r_bit == BIT_LAST);

  // Next-state, bit count and sample-point decision
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    w_load      = 1'b0;
    if (w_wrap) begin
      unique case (r_state)
        ST_IDLE: w_sample = 1'b1;
        ST_PA: begin
          if (w_last_bit) begin
            w_state_nxt = ST_PB;
            w_bit_nxt   = 5'd0;
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end
        ST_PB: begin
          if (w_last_bit) begin
            if (r_short) begin
              w_sample = 1'b1;
            end else begin
              w_state_nxt = ST_PC;
              w_bit_nxt   = 5'd0;
            end
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end
        ST_PC: begin
          if (w_last_bit) begin
            w_sample = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_sample) begin
      w_bit_nxt = 5'd0;
      if (i_start) begin
        w_state_nxt = ST_PA;
        w_load      = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // State, bit count and the registered phase/busy decodes
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
      r_bit   <= 5'd0;
      r_busy  <= 1'b0;
      r_pav   <= 1'b0;
      r_pbv   <= 1'b0;
      r_pcv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_pav   <= (w_state_nxt == ST_PA);
      r_pbv   <= (w_state_nxt == ST_PB);
      r_pcv   <= (w_state_nxt == ST_PC);
    end
  end

  // Opcode and SHORT latch, loaded only when a sample sees START
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_op    <= 4'b0;
      r_short <= 1'b0;
    end else if (w_load) begin
      r_op    <= i_opin;
      r_short <= i_short;
    end
  end

  assign o_pav   = r_pav;
  assign o_pavn  = ~r_pav;
  assign o_pbv   = r_pbv;
  assign o_pcv   = r_pcv;
  assign o_op1v  = r_op[3];
  assign o_op2v  = r_op[2];
  assign o_op3v  = r_op[1];
  assign o_op4v  = r_op[0];
  assign o_op1vn = ~r_op[3];
  assign o_op2vn = ~r_op[2];
  assign o_op3vn = ~r_op[1];
  assign o_op4vn = ~r_op[0];
  assign o_bit   = r_bit;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_lvdc_timing_seq.sv
// tb/tb_lvdc_timing_seq.sv - directed self-checking bench for lvdc_timing_seq
module tb_lvdc_timing_seq;

  localparam logic [1:0] PH_I = 2'd0;
  localparam logic [1:0] PH_A = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  localparam logic [1:0] PH_C = 2'd3;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [3:0] opin;
  logic       shrt;
  logic       halt;
  logic       v1, w1, x3, z3, zn, y7;
  logic       pav, pavn, pbv, pcv;
  logic       op1v, op2v, op3v, op4v;
  logic       op1vn, op2vn, op3vn, op4vn;
  logic [4:0] bitc;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  lvdc_timing_seq dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_start  (start),
    .i_opin   (opin),
    .i_short  (shrt),
    .i_halt   (halt),
    .o_v1     (v1),
    .o_w1     (w1),
    .o_x3     (x3),
    .o_z3     (z3),
    .o_zn     (zn),
    .o_y7     (y7),
    .o_pav    (pav),
    .o_pavn   (pavn),
    .o_pbv    (pbv),
    .o_pcv    (pcv),
    .o_op1v   (op1v),
    .o_op2v   (op2v),
    .o_op3v   (op3v),
    .o_op4v   (op4v),
    .o_op1vn  (op1vn),
    .o_op2vn  (op2vn),
    .o_op3vn  (op3vn),
    .o_op4vn  (op4vn),
    .o_bit    (bitc),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {v1, w1, x3, z3, zn, y7, pav, pavn, pbv, pcv,
                op1v, op2v, op3v, op4v, op1vn, op2vn, op3vn, op4vn, bitc, busy};

  function automatic logic [23:0] exp_vec(input logic [2:0] sp, input logic [1:0] ph,
                                          input logic [4:0] b, input logic [3:0] op,
                                          input logic on);
    logic [5:0] p;
    p = 6'b0;
    if (on) begin
      case (sp)
        3'd0: p = 6'b100000;
        3'd1: p = 6'b010000;
        3'd3: p = 6'b001000;
        3'd5: p = 6'b000100;
        3'd6: p = 6'b000010;
        3'd7: p = 6'b000001;
        default: p = 6'b000000;
      endcase
    end
    return {p, ph == PH_A, ph != PH_A, ph == PH_B, ph == PH_C, op, ~op, b, ph != PH_I};
  endfunction

  task automatic check(input string name, input logic [23:0] e);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, obs, e);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         adv;
    logic       start;
    logic [3:0] opin;
    logic       shrt;
    logic [2:0] sp;
    logic [1:0] ph;
    logic [4:0] bitv;
    logic [3:0] op;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // adv, start, opin, short -> sp, phase, bit, op
    tbl[0]  = '{1,   1'b1, 4'b1010, 1'b0, 3'd0, PH_A, 5'd0,  4'b1010};
    tbl[1]  = '{7,   1'b0, 4'b0000, 1'b0, 3'd7, PH_A, 5'd0,  4'b1010};
    tbl[2]  = '{1,   1'b0, 4'b0000, 1'b0, 3'd0, PH_A, 5'd1,  4'b1010};
    tbl[3]  = '{199, 1'b0, 4'b0000, 1'b0, 3'd7, PH_A, 5'd25, 4'b1010};
    tbl[4]  = '{1,   1'b0, 4'b0000, 1'b0, 3'd0, PH_B, 5'd0,  4'b1010};
    tbl[5]  = '{207, 1'b0, 4'b0000, 1'b0, 3'd7, PH_B, 5'd25, 4'b1010};
    tbl[6]  = '{1,   1'b0, 4'b0000, 1'b0, 3'd0, PH_C, 5'd0,  4'b1010};
    tbl[7]  = '{100, 1'b0, 4'b0000, 1'b0, 3'd4, PH_C, 5'd12, 4'b1010};
    tbl[8]  = '{107, 1'b0, 4'b0000, 1'b0, 3'd7, PH_C, 5'd25, 4'b1010};
    tbl[9]  = '{1,   1'b0, 4'b0000, 1'b0, 3'd0, PH_I, 5'd0,  4'b1010};
    tbl[10] = '{7,   1'b0, 4'b0000, 1'b0, 3'd7, PH_I, 5'd0,  4'b1010};
    tbl[11] = '{1,   1'b1, 4'b0011, 1'b1, 3'd0, PH_A, 5'd0,  4'b0011};
    tbl[12] = '{208, 1'b1, 4'b1100, 1'b1, 3'd0, PH_B, 5'd0,  4'b0011};
    tbl[13] = '{207, 1'b1, 4'b1100, 1'b1, 3'd7, PH_B, 5'd25, 4'b0011};
    tbl[14] = '{1,   1'b1, 4'b1100, 1'b1, 3'd0, PH_A, 5'd0,  4'b1100};
    tbl[15] = '{208, 1'b0, 4'b0000, 1'b1, 3'd0, PH_B, 5'd0,  4'b1100};
    tbl[16] = '{208, 1'b0, 4'b0000, 1'b1, 3'd0, PH_I, 5'd0,  4'b1100};

    resetn = 1'b0;
    start  = 1'b0;
    opin   = 4'b0;
    shrt   = 1'b0;
    halt   = 1'b0;

    // Reset state
    tick_n(2);
    check("reset_state", exp_vec(3'd7, PH_I, 5'd0, 4'b0, 1'b0));
    resetn = 1'b1;

    // Free-running pulses in IDLE, V1 first
    for (int k = 0; k < 32; k++) begin
      tick_n(1);
      check($sformatf("idle_pulse[%0d]", k), exp_vec(3'(k % 8), PH_I, 5'd0, 4'b0, 1'b1));
    end

    // Full and SHORT instruction cycles
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start;
      opin  = tbl[i].opin;
      shrt  = tbl[i].shrt;
      tick_n(tbl[i].adv);
      check($sformatf("tbl[%0d]", i), exp_vec(tbl[i].sp, tbl[i].ph, tbl[i].bitv, tbl[i].op, 1'b1));
    end

    // HALT mid-PB at BIT=10, SP=3
    start = 1'b0;
    shrt  = 1'b0;
    tick_n(7);
    start = 1'b1;
    opin  = 4'b0101;
    tick_n(1);
    check("halt_pa_start", exp_vec(3'd0, PH_A, 5'd0, 4'b0101, 1'b1));
    start = 1'b0;
    opin  = 4'b0000;
    tick_n(208);
    check("halt_pb_start", exp_vec(3'd0, PH_B, 5'd0, 4'b0101, 1'b1));
    tick_n(83);
    check("halt_pre", exp_vec(3'd3, PH_B, 5'd10, 4'b0101, 1'b1));
    halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_n(1);
      check($sformatf("halt_frozen[%0d]", k), exp_vec(3'd3, PH_B, 5'd10, 4'b0101, 1'b0));
    end
    halt = 1'b0;
    tick_n(1);
    check("halt_resume_sp4", exp_vec(3'd4, PH_B, 5'd10, 4'b0101, 1'b1));
    tick_n(1);
    check("halt_resume_z3", exp_vec(3'd5, PH_B, 5'd10, 4'b0101, 1'b1));
    tick_n(122);
    check("halt_pb_last", exp_vec(3'd7, PH_B, 5'd25, 4'b0101, 1'b1));
    tick_n(1);
    check("halt_pb_213", exp_vec(3'd0, PH_C, 5'd0, 4'b0101, 1'b1));

    // Reset mid-PC at BIT=17
    tick_n(139);
    check("pc_bit17", exp_vec(3'd3, PH_C, 5'd17, 4'b0101, 1'b1));
    resetn = 1'b0;
    #1;
    check("rst_immediate", exp_vec(3'd7, PH_I, 5'd0, 4'b0, 1'b0));
    tick_n(2);
    check("rst_hold", exp_vec(3'd7, PH_I, 5'd0, 4'b0, 1'b0));
    resetn = 1'b1;
    tick_n(1);
    check("rst_release_v1", exp_vec(3'd0, PH_I, 5'd0, 4'b0, 1'b1));
    tick_n(20);
    check("rst_idle_stays", exp_vec(3'd4, PH_I, 5'd0, 4'b0, 1'b1));

    // HALT and START together at a sample point: HALT wins, START re-sampled
    tick_n(3);
    start = 1'b1;
    halt  = 1'b1;
    opin  = 4'b1111;
    tick_n(1);
    check("halt_vs_start", exp_vec(3'd7, PH_I, 5'd0, 4'b0, 1'b0));
    halt = 1'b0;
    tick_n(1);
    check("start_after_halt", exp_vec(3'd0, PH_A, 5'd0, 4'b1111, 1'b1));
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
